vreg_wr_sched: RTL and testbench

Write-back scheduler between the write-back unit's NUM_REQ request ports and the vector register file's single write port. It grants one requester per cycle in round-robin order and queues the granted writes in a QDEPTH-entry FIFO. The FIFO head is presented to the register file on a valid/ready handshake. A per-register busy vector marks registers with queued or in-flight writes, for hazard checks by issue logic.

---
 rtl/vreg_wr_sched_if.sv | 40 ++++
 rtl/vreg_wr_sched.sv | 113 +++++++++++
 tb/tb_vreg_wr_sched.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vreg_wr_sched_if.sv
// Bundle between the write-back requesters, the scheduler and the register file write port.
// The scheduler takes the slave view; the requesters/register file side takes the master view.
interface vreg_wr_sched_if #(
    parameter int NUM_REQ           = 3,
    parameter int NUM_OF_VECTOR_REG = 32,
    parameter int ADDR_FIELD_WIDTH  = 6,
    parameter int DATA_W            = 64,
    parameter int QDEPTH            = 4
);
    localparam int PTR_W = $clog2(NUM_OF_VECTOR_REG);
    localparam int CNT_W = $clog2(QDEPTH + 1);

    logic [NUM_REQ-1:0]                       req_vld;
    logic [NUM_REQ-1:0][PTR_W-1:0]            req_vec_reg_ptr;
    logic [NUM_REQ-1:0][ADDR_FIELD_WIDTH-1:0] req_addr;
    logic [NUM_REQ-1:0][DATA_W-1:0]           req_data;
    logic [NUM_REQ-1:0]                       req_grant;

    logic                        rf_wr_vld;
    logic [PTR_W-1:0]            rf_wr_vec_reg_ptr;
    logic [ADDR_FIELD_WIDTH-1:0] rf_wr_addr;
    logic [DATA_W-1:0]           rf_wr_data;
    logic                        rf_wr_rdy;

    logic [NUM_OF_VECTOR_REG-1:0] vreg_busy;
    logic [CNT_W-1:0]             q_count;
    logic                         q_full;

    modport slave (
        input  req_vld, req_vec_reg_ptr, req_addr, req_data, rf_wr_rdy,
        output req_grant, rf_wr_vld, rf_wr_vec_reg_ptr, rf_wr_addr, rf_wr_data,
               vreg_busy, q_count, q_full
    );

    modport master (
        output req_vld, req_vec_reg_ptr, req_addr, req_data, rf_wr_rdy,
        input  req_grant, rf_wr_vld, rf_wr_vec_reg_ptr, rf_wr_addr, rf_wr_data,
               vreg_busy, q_count, q_full
    );
endinterface

// File: rtl/vreg_wr_sched.sv
// Round-robin write-back scheduler: one grant per cycle into a small FIFO that feeds the
// vector register file write port, plus per-register busy tracking for hazard checks.
module vreg_wr_sched #(
    parameter int NUM_REQ           = 3,
    parameter int NUM_OF_VECTOR_REG = 32,
    parameter int ADDR_FIELD_WIDTH  = 6,
    parameter int DATA_W            = 64,
    parameter int QDEPTH            = 4
) (
    input  logic          clk_i,
    input  logic          reset_ni,
    vreg_wr_sched_if.slave bus
);
    localparam int PTR_W = $clog2(NUM_OF_VECTOR_REG);
    localparam int CNT_W = $clog2(QDEPTH + 1);
    localparam int AW    = $clog2(QDEPTH);
    localparam int RR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [RR_W-1:0]  rr_q, rr_d;
    logic [AW-1:0]    wr_q, rd_q;
    logic [CNT_W-1:0] cnt_q;

    logic [PTR_W-1:0]            fifo_ptr_q  [QDEPTH];
    logic [ADDR_FIELD_WIDTH-1:0] fifo_addr_q [QDEPTH];
    logic [DATA_W-1:0]           fifo_data_q [QDEPTH];

    logic            win_vld;
    logic [RR_W-1:0] win_idx;
    logic            full, push, pop;
    logic [PTR_W-1:0] win_ptr, head_ptr;

    // Search starts at the round-robin pointer and wraps once around the requesters.
    always_comb begin
        int idx;
        win_vld = 1'b0;
        win_idx = '0;
        idx     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_q) + k) % NUM_REQ;
            if (!win_vld && bus.req_vld[idx]) begin
                win_vld = 1'b1;
                win_idx = RR_W'(idx);
            end
        end
    end

    // A full queue never grants, even when popping this cycle.
    assign full     = (cnt_q == CNT_W'(QDEPTH));
    assign push     = win_vld && reset_ni && !full;
    assign pop      = (cnt_q != '0) && bus.rf_wr_rdy;
    assign win_ptr  = bus.req_vec_reg_ptr[win_idx];
    assign head_ptr = fifo_ptr_q[rd_q];
    assign rr_d     = (win_idx == RR_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_grant
        assign bus.req_grant[gi] = push && (win_idx == RR_W'(gi));
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            rr_q  <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                fifo_ptr_q[i]  <= '0;
                fifo_addr_q[i] <= '0;
                fifo_data_q[i] <= '0;
            end
        end else begin
            if (push) begin
                fifo_ptr_q[wr_q]  <= win_ptr;
                fifo_addr_q[wr_q] <= bus.req_addr[win_idx];
                fifo_data_q[wr_q] <= bus.req_data[win_idx];
                wr_q              <= wr_q + 1'b1;
                rr_q              <= rr_d;
            end
            if (pop) begin
                rd_q <= rd_q + 1'b1;
            end
            if (push && !pop) begin
                cnt_q <= cnt_q + 1'b1;
            end else if (pop && !push) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    // One occupancy counter per register; simultaneous push and pop of r cancel out.
    for (genvar gi = 0; gi < NUM_OF_VECTOR_REG; gi++) begin : g_busy
        logic [CNT_W-1:0] busy_cnt_q;
        logic             inc, dec;
        assign inc = push && (win_ptr == PTR_W'(gi));
        assign dec = pop && (head_ptr == PTR_W'(gi));
        always_ff @(posedge clk_i) begin
            if (!reset_ni) begin
                busy_cnt_q <= '0;
            end else if (inc && !dec) begin
                busy_cnt_q <= busy_cnt_q + 1'b1;
            end else if (dec && !inc) begin
                busy_cnt_q <= busy_cnt_q - 1'b1;
            end
        end
        assign bus.vreg_busy[gi] = (busy_cnt_q != '0);
    end

    assign bus.rf_wr_vld         = (cnt_q != '0);
    assign bus.rf_wr_vec_reg_ptr = head_ptr;
    assign bus.rf_wr_addr        = fifo_addr_q[rd_q];
    assign bus.rf_wr_data        = fifo_data_q[rd_q];
    assign bus.q_count           = cnt_q;
    assign bus.q_full            = full;
endmodule

// File: tb/tb_vreg_wr_sched.sv
// Self-checking bench for vreg_wr_sched: randomized requests against a queue-based model
// of round-robin arbitration, FIFO ordering and per-register busy status.
module tb_vreg_wr_sched;
    localparam int N  = 3;
    localparam int NV = 32;
    localparam int AD = 6;
    localparam int DW = 64;
    localparam int QD = 4;
    localparam int PW = 5;
    localparam int CW = 3;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    vreg_wr_sched_if #(.NUM_REQ(N), .NUM_OF_VECTOR_REG(NV), .ADDR_FIELD_WIDTH(AD),
                       .DATA_W(DW), .QDEPTH(QD)) bus ();

    vreg_wr_sched #(.NUM_REQ(N), .NUM_OF_VECTOR_REG(NV), .ADDR_FIELD_WIDTH(AD),
                    .DATA_W(DW), .QDEPTH(QD)) dut (
        .clk_i   (clk),
        .reset_ni(reset_n),
        .bus     (bus)
    );

    typedef struct {
        logic [PW-1:0] ptr;
        logic [AD-1:0] addr;
        logic [DW-1:0] data;
    } ent_t;

    ent_t mq[$];
    int   m_rr   = 0;
    int   last_g = -1;
    int   n_pass = 0;
    int   n_chk  = 0;

    function automatic int exp_grant();
        if (!reset_n || mq.size() == QD) return -1;
        for (int k = 0; k < N; k++) begin
            if (bus.req_vld[(m_rr + k) % N]) return (m_rr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_grant_vec();
        int g;
        logic [N-1:0] v;
        g = exp_grant();
        v = '0;
        if (g >= 0) v[g] = 1'b1;
        return v;
    endfunction

    function automatic logic [NV-1:0] exp_busy();
        logic [NV-1:0] b;
        b = '0;
        foreach (mq[i]) b[mq[i].ptr] = 1'b1;
        return b;
    endfunction

    // Advance one clock and apply the same edge to the model.
    task automatic tick();
        int   g;
        bit   p;
        ent_t e;
        g = exp_grant();
        p = (mq.size() != 0) && bus.rf_wr_rdy;
        e = '{ptr: '0, addr: '0, data: '0};
        if (g >= 0) begin
            e.ptr  = bus.req_vec_reg_ptr[g];
            e.addr = bus.req_addr[g];
            e.data = bus.req_data[g];
        end
        @(posedge clk);
        #1;
        if (!reset_n) begin
            mq.delete();
            m_rr = 0;
            g = -1;
        end else begin
            if (p) void'(mq.pop_front());
            if (g >= 0) begin
                mq.push_back(e);
                m_rr = (g + 1) % N;
            end
        end
        last_g = g;
    endtask

    task automatic new_req(input int i, input bit v);
        bus.req_vld[i]         = v;
        bus.req_vec_reg_ptr[i] = PW'($urandom_range(0, NV - 1));
        bus.req_addr[i]        = AD'($urandom);
        bus.req_data[i]        = {$urandom, $urandom};
    endtask

    task automatic drain();
        bus.req_vld   = '0;
        bus.rf_wr_rdy = 1'b1;
        for (int c = 0; c < 8 && mq.size() != 0; c++) tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        for (int i = 0; i < N; i++) new_req(i, 1'b1);
        bus.rf_wr_rdy = 1'b1;
        #1;
        n_chk++;
        if (bus.req_grant !== 3'b000) $display("FAIL reset_grant got=%b want=000", bus.req_grant);
        else n_pass++;
        tick();
        tick();
        reset_n     = 1'b1;
        bus.req_vld = '0;
        #1;
        n_chk++;
        if ({bus.rf_wr_vld, bus.q_count, bus.q_full, bus.vreg_busy, bus.req_grant} !== '0)
            $display("FAIL reset_state got vld=%b cnt=%0d full=%b busy=%h grant=%b want all zero",
                     bus.rf_wr_vld, bus.q_count, bus.q_full, bus.vreg_busy, bus.req_grant);
        else n_pass++;
    endtask

    task automatic test_single();
        bus.req_vld            = 3'b001;
        bus.req_vec_reg_ptr[0] = 5'd5;
        bus.req_addr[0]        = 6'd3;
        bus.req_data[0]        = 64'hA5;
        bus.rf_wr_rdy          = 1'b1;
        #1;
        n_chk++;
        if (bus.req_grant !== 3'b001) $display("FAIL single_grant got=%b want=001", bus.req_grant);
        else n_pass++;
        tick();
        bus.req_vld = '0;
        #1;
        n_chk++;
        if ({bus.rf_wr_vld, bus.rf_wr_vec_reg_ptr, bus.rf_wr_addr, bus.rf_wr_data, bus.vreg_busy[5]}
            !== {1'b1, 5'd5, 6'd3, 64'hA5, 1'b1})
            $display("FAIL single_head got vld=%b ptr=%0d addr=%0d data=%h busy5=%b want 1/5/3/a5/1",
                     bus.rf_wr_vld, bus.rf_wr_vec_reg_ptr, bus.rf_wr_addr, bus.rf_wr_data, bus.vreg_busy[5]);
        else n_pass++;
        tick();
        n_chk++;
        if ({bus.rf_wr_vld, bus.vreg_busy[5]} !== 2'b00)
            $display("FAIL single_retire got vld=%b busy5=%b want 0/0", bus.rf_wr_vld, bus.vreg_busy[5]);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        drain();
        for (int i = 0; i < N; i++) new_req(i, 1'b1);
        bus.rf_wr_rdy = 1'b1;
        for (int c = 0; c < 9; c++) begin
            #1;
            n_chk++;
            if ({bus.req_grant, bus.rf_wr_vld, bus.q_count, bus.q_full, bus.vreg_busy} !==
                {exp_grant_vec(), mq.size() != 0, CW'(mq.size()), mq.size() == QD, exp_busy()})
                $display("FAIL rr_status c=%0d got grant=%b vld=%b cnt=%0d busy=%h want grant=%b cnt=%0d busy=%h",
                         c, bus.req_grant, bus.rf_wr_vld, bus.q_count, bus.vreg_busy,
                         exp_grant_vec(), mq.size(), exp_busy());
            else n_pass++;
            if (mq.size() != 0) begin
                n_chk++;
                if ({bus.rf_wr_vec_reg_ptr, bus.rf_wr_addr, bus.rf_wr_data} !== {mq[0].ptr, mq[0].addr, mq[0].data})
                    $display("FAIL rr_head c=%0d got %0d/%0d/%h want %0d/%0d/%h", c, bus.rf_wr_vec_reg_ptr,
                             bus.rf_wr_addr, bus.rf_wr_data, mq[0].ptr, mq[0].addr, mq[0].data);
                else n_pass++;
            end
            tick();
            if (last_g >= 0) new_req(last_g, 1'b1);
        end
    endtask

    task automatic test_full();
        ent_t h;
        drain();
        bus.rf_wr_rdy = 1'b0;
        for (int i = 0; i < N; i++) new_req(i, 1'b1);
        for (int c = 0; c < QD; c++) begin
            #1;
            n_chk++;
            if (bus.req_grant !== exp_grant_vec() || bus.req_grant == '0)
                $display("FAIL full_fill_grant c=%0d got=%b want=%b", c, bus.req_grant, exp_grant_vec());
            else n_pass++;
            tick();
            if (last_g >= 0) new_req(last_g, 1'b1);
        end
        #1;
        n_chk++;
        if ({bus.q_full, bus.q_count, bus.req_grant} !== {1'b1, 3'd4, 3'b000})
            $display("FAIL full_state got full=%b cnt=%0d grant=%b want 1/4/000", bus.q_full, bus.q_count, bus.req_grant);
        else n_pass++;
        h = mq[0];
        for (int c = 0; c < 2; c++) begin
            n_chk++;
            if ({bus.rf_wr_vec_reg_ptr, bus.rf_wr_addr, bus.rf_wr_data} !== {h.ptr, h.addr, h.data})
                $display("FAIL full_head_stable got %0d/%0d/%h want %0d/%0d/%h", bus.rf_wr_vec_reg_ptr,
                         bus.rf_wr_addr, bus.rf_wr_data, h.ptr, h.addr, h.data);
            else n_pass++;
            tick();
        end
        bus.rf_wr_rdy = 1'b1;
        #1;
        n_chk++;
        if (bus.req_grant !== 3'b000) $display("FAIL full_no_passthru got=%b want=000", bus.req_grant);
        else n_pass++;
        tick();
        bus.rf_wr_rdy = 1'b0;
        #1;
        n_chk++;
        if (bus.q_count !== 3'd3 || $countones(bus.req_grant) != 1 || bus.req_grant !== exp_grant_vec())
            $display("FAIL full_one_slot got cnt=%0d grant=%b want cnt=3 grant=%b", bus.q_count, bus.req_grant, exp_grant_vec());
        else n_pass++;
        tick();
        if (last_g >= 0) new_req(last_g, 1'b1);
        #1;
        n_chk++;
        if ({bus.q_full, bus.req_grant} !== {1'b1, 3'b000})
            $display("FAIL full_refull got full=%b grant=%b want 1/000", bus.q_full, bus.req_grant);
        else n_pass++;
    endtask

    task automatic test_busy();
        drain();
        bus.rf_wr_rdy = 1'b0;
        for (int i = 0; i < N; i++) begin
            new_req(i, 1'b0);
            bus.req_vec_reg_ptr[i] = 5'd7;
        end
        bus.req_vld = 3'b001;
        tick();
        bus.req_vld = 3'b010;
        tick();
        bus.req_vld = '0;
        #1;
        n_chk++;
        if ({bus.vreg_busy[7], bus.q_count} !== {1'b1, 3'd2})
            $display("FAIL busy_two got busy7=%b cnt=%0d want 1/2", bus.vreg_busy[7], bus.q_count);
        else n_pass++;
        bus.rf_wr_rdy = 1'b1;
        tick();
        n_chk++;
        if ({bus.vreg_busy[7], bus.q_count} !== {1'b1, 3'd1})
            $display("FAIL busy_one_pop got busy7=%b cnt=%0d want 1/1", bus.vreg_busy[7], bus.q_count);
        else n_pass++;
        bus.req_vld = 3'b100;
        tick();
        bus.req_vld   = '0;
        bus.rf_wr_rdy = 1'b0;
        #1;
        n_chk++;
        if ({bus.vreg_busy[7], bus.q_count, bus.vreg_busy} !== {1'b1, 3'd1, exp_busy()})
            $display("FAIL busy_push_pop got busy7=%b cnt=%0d want 1/1", bus.vreg_busy[7], bus.q_count);
        else n_pass++;
        bus.rf_wr_rdy = 1'b1;
        tick();
        n_chk++;
        if ({bus.vreg_busy[7], bus.q_count} !== {1'b0, 3'd0})
            $display("FAIL busy_clear got busy7=%b cnt=%0d want 0/0", bus.vreg_busy[7], bus.q_count);
        else n_pass++;
    endtask

    task automatic test_wrap();
        int issued = 0;
        int c = 0;
        drain();
        while ((issued < 10 || bus.req_vld != '0 || mq.size() != 0) && c < 200) begin
            for (int i = 0; i < N; i++) begin
                if (!bus.req_vld[i] && issued < 10 && $urandom_range(0, 1) == 1) begin
                    new_req(i, 1'b1);
                    issued++;
                end
            end
            bus.rf_wr_rdy = 1'($urandom_range(0, 1));
            #1;
            n_chk++;
            if ({bus.req_grant, bus.rf_wr_vld, bus.q_count, bus.q_full, bus.vreg_busy} !==
                {exp_grant_vec(), mq.size() != 0, CW'(mq.size()), mq.size() == QD, exp_busy()} || bus.q_count > 3'd4)
                $display("FAIL wrap_status c=%0d got grant=%b cnt=%0d busy=%h want grant=%b cnt=%0d busy=%h",
                         c, bus.req_grant, bus.q_count, bus.vreg_busy, exp_grant_vec(), mq.size(), exp_busy());
            else n_pass++;
            if (mq.size() != 0) begin
                n_chk++;
                if ({bus.rf_wr_vec_reg_ptr, bus.rf_wr_addr, bus.rf_wr_data} !== {mq[0].ptr, mq[0].addr, mq[0].data})
                    $display("FAIL wrap_head c=%0d got %0d/%0d/%h want %0d/%0d/%h", c, bus.rf_wr_vec_reg_ptr,
                             bus.rf_wr_addr, bus.rf_wr_data, mq[0].ptr, mq[0].addr, mq[0].data);
                else n_pass++;
            end
            tick();
            if (last_g >= 0) bus.req_vld[last_g] = 1'b0;
            c++;
        end
        n_chk++;
        if (c >= 200) $display("FAIL wrap_timeout got cycles=%0d want <200", c);
        else n_pass++;
    endtask

    task automatic test_mid_reset();
        drain();
        bus.rf_wr_rdy = 1'b0;
        for (int i = 0; i < N; i++) new_req(i, 1'b1);
        for (int c = 0; c < 3; c++) begin
            tick();
            if (last_g >= 0) new_req(last_g, 1'b1);
        end
        #1;
        n_chk++;
        if ({bus.q_count, bus.rf_wr_vld} !== {3'd3, 1'b1})
            $display("FAIL mrst_pre got cnt=%0d vld=%b want 3/1", bus.q_count, bus.rf_wr_vld);
        else n_pass++;
        reset_n = 1'b0;
        #1;
        n_chk++;
        if (bus.req_grant !== 3'b000) $display("FAIL mrst_grant got=%b want=000", bus.req_grant);
        else n_pass++;
        tick();
        reset_n = 1'b1;
        #1;
        n_chk++;
        if ({bus.rf_wr_vld, bus.q_count, bus.vreg_busy, bus.req_grant} !== {1'b0, 3'd0, 32'd0, 3'b001})
            $display("FAIL mrst_post got vld=%b cnt=%0d busy=%h grant=%b want 0/0/0/001",
                     bus.rf_wr_vld, bus.q_count, bus.vreg_busy, bus.req_grant);
        else n_pass++;
        tick();
    endtask

    initial begin
        bus.req_vld         = '0;
        bus.req_vec_reg_ptr = '0;
        bus.req_addr        = '0;
        bus.req_data        = '0;
        bus.rf_wr_rdy       = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_full();
        test_busy();
        test_wrap();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
